// File: rtl/nrisc_data_mem.sv
// nrisc_data_mem: data memory and memory-mapped peripherals for the nRISC core.
//
// Address map (word addresses):
//   0 .. 2^DEPTH_LOG2-1 : RAM (contents not cleared by reset)
//   0xFF00              : GPIO_out register (R/W)
//   0xFF01              : GPIO_in (read-only, writes ignored)
//   0xFF02              : TCOUNT  (R/W)            -- timer build only
//   0xFF03              : TCMP    (R/W)            -- timer build only
//   0xFF04              : TCTRL {AUTORELOAD, FLAG, EN}, FLAG is write-1-to-clear
//   anything else       : unmapped, reads 0, writes ignored
//
// Build option: define NRISC_DMEM_TIMER_EN to include the timer. Without it,
// 0xFF02..0xFF04 are unmapped and TIMER_irq is tied low.
//
// Ports:
//   clk             : clock, all state changes on the rising edge
//   rst             : asynchronous active-low reset
//   CORE_DATA_ADDR  : word address from the CPU
//   DATA_IN         : write data from the CPU
//   CORE_DATA_write : write strobe (wins over a simultaneous load)
//   CORE_DATA_load  : load strobe
//   DATA_Out        : registered read data, held between loads
//   DATA_valid      : one-cycle pulse after an accepted load
//   GPIO_in         : external input word
//   GPIO_out        : registered output word
//   TIMER_irq       : level copy of the timer match flag
module nrisc_data_mem #(
  parameter int unsigned TAM        = 16,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TAM-1:0] CORE_DATA_ADDR,
  input  logic [TAM-1:0] DATA_IN,
  input  logic           CORE_DATA_write,
  input  logic           CORE_DATA_load,
  output logic [TAM-1:0] DATA_Out,
  output logic           DATA_valid,
  input  logic [TAM-1:0] GPIO_in,
  output logic [TAM-1:0] GPIO_out,
  output logic           TIMER_irq
);

  localparam logic [TAM-1:0] ADDR_GPO   = TAM'('hFF00);
  localparam logic [TAM-1:0] ADDR_GPI   = TAM'('hFF01);
`ifdef NRISC_DMEM_TIMER_EN
  localparam logic [TAM-1:0] ADDR_TCNT  = TAM'('hFF02);
  localparam logic [TAM-1:0] ADDR_TCMP  = TAM'('hFF03);
  localparam logic [TAM-1:0] ADDR_TCTRL = TAM'('hFF04);
`endif

  logic [TAM-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  logic           in_ram;
  logic           sel_gpo;
  logic           sel_gpi;
  logic           ld_acc;
  logic [TAM-1:0] rd_data;

  assign in_ram  = (CORE_DATA_ADDR >> DEPTH_LOG2) == '0;
  assign sel_gpo = !in_ram && (CORE_DATA_ADDR == ADDR_GPO);
  assign sel_gpi = !in_ram && (CORE_DATA_ADDR == ADDR_GPI);
  // A write on the same edge suppresses the load entirely.
  assign ld_acc  = CORE_DATA_load && !CORE_DATA_write;

`ifdef NRISC_DMEM_TIMER_EN
  logic           sel_tcnt;
  logic           sel_tcmp;
  logic           sel_tctrl;
  logic [TAM-1:0] tcount;
  logic [TAM-1:0] tcmp;
  logic           t_en;
  logic           t_flag;
  logic           t_ar;
  logic           t_match;

  assign sel_tcnt  = !in_ram && (CORE_DATA_ADDR == ADDR_TCNT);
  assign sel_tcmp  = !in_ram && (CORE_DATA_ADDR == ADDR_TCMP);
  assign sel_tctrl = !in_ram && (CORE_DATA_ADDR == ADDR_TCTRL);
  assign t_match   = t_en && (tcount == tcmp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcount <= '0;
      tcmp   <= '1;
      t_en   <= 1'b0;
      t_flag <= 1'b0;
      t_ar   <= 1'b0;
    end else begin
      // CPU write to TCOUNT overrides both increment and auto-reload.
      if (CORE_DATA_write && sel_tcnt)
        tcount <= DATA_IN;
      else if (t_match && t_ar)
        tcount <= '0;
      else if (t_en)
        tcount <= tcount + TAM'(1);

      if (CORE_DATA_write && sel_tcmp)
        tcmp <= DATA_IN;

      if (CORE_DATA_write && sel_tctrl) begin
        t_en <= DATA_IN[0];
        t_ar <= DATA_IN[2];
      end

      // A match on the same edge as a write-1-to-clear keeps the flag set.
      if (t_match)
        t_flag <= 1'b1;
      else if (CORE_DATA_write && sel_tctrl && DATA_IN[1])
        t_flag <= 1'b0;
    end
  end

  assign TIMER_irq = t_flag;
`else
  assign TIMER_irq = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (in_ram)
      rd_data = mem[CORE_DATA_ADDR[DEPTH_LOG2-1:0]];
    else if (sel_gpo)
      rd_data = GPIO_out;
    else if (sel_gpi)
      rd_data = GPIO_in;
`ifdef NRISC_DMEM_TIMER_EN
    else if (sel_tcnt)
      rd_data = tcount;
    else if (sel_tcmp)
      rd_data = tcmp;
    else if (sel_tctrl)
      rd_data = {{(TAM-3){1'b0}}, t_ar, t_flag, t_en};
`endif
  end

  // RAM is never cleared; the reset only blocks writes on edges where rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (rst && CORE_DATA_write && in_ram)
      mem[CORE_DATA_ADDR[DEPTH_LOG2-1:0]] <= DATA_IN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DATA_Out   <= '0;
      DATA_valid <= 1'b0;
      GPIO_out   <= '0;
    end else begin
      DATA_valid <= ld_acc;
      if (ld_acc)
        DATA_Out <= rd_data;
      if (CORE_DATA_write && sel_gpo)
        GPIO_out <= DATA_IN;
    end
  end

endmodule

// File: tb/tb_nrisc_data_mem.sv
// Testbench for nrisc_data_mem: table of single-edge bus operations with
// expected DATA_Out / DATA_valid / GPIO_out, plus hand-written timer and
// reset sequences. Timer expectations follow NRISC_DMEM_TIMER_EN.
module tb_nrisc_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] din;
  logic        wr;
  logic        ld;
  logic [15:0] gpio_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic [15:0] gpio_out;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  nrisc_data_mem #(.TAM(16), .DEPTH_LOG2(10)) dut (
    .clk             (clk),
    .rst             (rst),
    .CORE_DATA_ADDR  (addr),
    .DATA_IN         (din),
    .CORE_DATA_write (wr),
    .CORE_DATA_load  (ld),
    .DATA_Out        (data_out),
    .DATA_valid      (data_valid),
    .GPIO_in         (gpio_in),
    .GPIO_out        (gpio_out),
    .TIMER_irq       (timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic        l;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] gi;
    logic [15:0] exp_out;
    logic        exp_vld;
    logic [15:0] exp_gpo;
  } vec_t;

  vec_t tv [21];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus operation spanning exactly one rising edge; outputs sampled 1 time unit later.
  task automatic bus(input logic w, input logic l, input logic [15:0] a, input logic [15:0] d);
    wr   = w;
    ld   = l;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    ld = 1'b0;
  endtask

  initial begin
    //           w     l     addr      data      gpio_in   out       vld   gpo
    tv[0]  = '{1'b1, 1'b0, 16'h0005, 16'h1234, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tv[1]  = '{1'b0, 1'b1, 16'h0005, 16'h0000, 16'h0000, 16'h1234, 1'b1, 16'h0000};
    tv[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1'b0, 16'h0000};
    tv[3]  = '{1'b1, 1'b1, 16'h0007, 16'hAAAA, 16'h0000, 16'h1234, 1'b0, 16'h0000};
    tv[4]  = '{1'b0, 1'b1, 16'h0007, 16'h0000, 16'h0000, 16'hAAAA, 1'b1, 16'h0000};
    tv[5]  = '{1'b0, 1'b1, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    tv[6]  = '{1'b1, 1'b0, 16'h0000, 16'h1111, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tv[7]  = '{1'b1, 1'b0, 16'h8000, 16'hDEAD, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    tv[8]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 1'b1, 16'h0000};
    tv[9]  = '{1'b1, 1'b0, 16'hFF01, 16'hFFFF, 16'h5A5A, 16'h1111, 1'b0, 16'h0000};
    tv[10] = '{1'b0, 1'b1, 16'hFF01, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b1, 16'h0000};
    tv[11] = '{1'b1, 1'b0, 16'hFF00, 16'hC3C3, 16'h0000, 16'h5A5A, 1'b0, 16'hC3C3};
    tv[12] = '{1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h0000, 16'hC3C3, 1'b1, 16'hC3C3};
    tv[13] = '{1'b1, 1'b0, 16'h03FF, 16'hBEEF, 16'h0000, 16'hC3C3, 1'b0, 16'hC3C3};
    tv[14] = '{1'b0, 1'b1, 16'h03FF, 16'h0000, 16'h0000, 16'hBEEF, 1'b1, 16'hC3C3};
    tv[15] = '{1'b1, 1'b0, 16'h0400, 16'h7777, 16'h0000, 16'hBEEF, 1'b0, 16'hC3C3};
    tv[16] = '{1'b0, 1'b1, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'hC3C3};
    tv[17] = '{1'b0, 1'b1, 16'h0005, 16'h0000, 16'h0000, 16'h1234, 1'b1, 16'hC3C3};
    tv[18] = '{1'b0, 1'b1, 16'hFF05, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'hC3C3};
    tv[19] = '{1'b0, 1'b1, 16'h0007, 16'h0000, 16'h0000, 16'hAAAA, 1'b1, 16'hC3C3};
    tv[20] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 1'b1, 16'hC3C3};

    rst = 1'b0; wr = 1'b0; ld = 1'b0; addr = '0; din = '0; gpio_in = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset DATA_Out", data_out, 16'h0000);
    check("reset DATA_valid", {15'b0, data_valid}, 16'h0000);
    check("reset GPIO_out", gpio_out, 16'h0000);
    check("reset TIMER_irq", {15'b0, timer_irq}, 16'h0000);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      gpio_in = tv[i].gi;
      bus(tv[i].w, tv[i].l, tv[i].a, tv[i].d);
      check($sformatf("vec%0d DATA_Out", i), data_out, tv[i].exp_out);
      check($sformatf("vec%0d DATA_valid", i), {15'b0, data_valid}, {15'b0, tv[i].exp_vld});
      check($sformatf("vec%0d GPIO_out", i), gpio_out, tv[i].exp_gpo);
    end
    gpio_in = '0;

`ifdef NRISC_DMEM_TIMER_EN
    // TCOUNT starts at 0 and counts from the edge after EN is written.
    bus(1'b1, 1'b0, 16'hFF03, 16'h0003);
    bus(1'b1, 1'b0, 16'hFF04, 16'h0005);
    bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("irq before match", {15'b0, timer_irq}, 16'h0000);
    bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("irq at match", {15'b0, timer_irq}, 16'h0001);
    bus(1'b0, 1'b1, 16'hFF02, 16'h0000);
    check("tcount reloaded", data_out, 16'h0000);
    bus(1'b0, 1'b1, 16'hFF04, 16'h0000);
    check("tctrl flag set", data_out, 16'h0007);
    bus(1'b1, 1'b0, 16'hFF04, 16'h0007);
    check("w1c clears irq", {15'b0, timer_irq}, 16'h0000);
    bus(1'b0, 1'b1, 16'hFF04, 16'h0000);
    check("tctrl en kept", data_out, 16'h0005);
    check("irq rematch", {15'b0, timer_irq}, 16'h0001);
    bus(1'b1, 1'b0, 16'hFF04, 16'h0007);
    check("w1c clears again", {15'b0, timer_irq}, 16'h0000);
    bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    bus(1'b1, 1'b0, 16'hFF04, 16'h0007);
    check("match beats clear", {15'b0, timer_irq}, 16'h0001);
    bus(1'b1, 1'b0, 16'hFF04, 16'h0002);
    check("disable and clear", {15'b0, timer_irq}, 16'h0000);
    bus(1'b1, 1'b0, 16'hFF03, 16'h0010);
    bus(1'b1, 1'b0, 16'hFF02, 16'hFFFF);
    bus(1'b1, 1'b0, 16'hFF04, 16'h0001);
    bus(1'b0, 1'b1, 16'hFF02, 16'h0000);
    check("tcount at max", data_out, 16'hFFFF);
    bus(1'b0, 1'b1, 16'hFF02, 16'h0000);
    check("tcount wrapped", data_out, 16'h0000);
    bus(1'b0, 1'b1, 16'hFF04, 16'h0000);
    check("no flag after wrap", data_out, 16'h0001);
    check("no irq after wrap", {15'b0, timer_irq}, 16'h0000);
`else
    bus(1'b1, 1'b0, 16'hFF03, 16'h0003);
    bus(1'b1, 1'b0, 16'hFF04, 16'h0005);
    bus(1'b1, 1'b0, 16'hFF02, 16'h0007);
    bus(1'b0, 1'b1, 16'hFF02, 16'h0000);
    check("no tcount", data_out, 16'h0000);
    bus(1'b0, 1'b1, 16'h0005, 16'h0000);
    check("ram between", data_out, 16'h1234);
    bus(1'b0, 1'b1, 16'hFF03, 16'h0000);
    check("no tcmp", data_out, 16'h0000);
    bus(1'b0, 1'b1, 16'h0005, 16'h0000);
    bus(1'b0, 1'b1, 16'hFF04, 16'h0000);
    check("no tctrl", data_out, 16'h0000);
    check("irq tied low", {15'b0, timer_irq}, 16'h0000);
`endif

    // Asynchronous reset mid-cycle with a DATA_valid pulse outstanding.
    bus(1'b1, 1'b0, 16'hFF00, 16'hA5A5);
    bus(1'b0, 1'b1, 16'h0005, 16'h0000);
    check("pre-reset DATA_Out", data_out, 16'h1234);
    check("pre-reset GPIO_out", gpio_out, 16'hA5A5);
    #2;
    rst = 1'b0;
    #1;
    check("async DATA_Out", data_out, 16'h0000);
    check("async DATA_valid", {15'b0, data_valid}, 16'h0000);
    check("async GPIO_out", gpio_out, 16'h0000);
    check("async TIMER_irq", {15'b0, timer_irq}, 16'h0000);
    // Write and load on an edge during reset are both discarded.
    wr = 1'b1; ld = 1'b1; addr = 16'h0005; din = 16'h9999;
    @(posedge clk);
    #1;
    wr = 1'b0; ld = 1'b0;
    check("reset-edge DATA_valid", {15'b0, data_valid}, 16'h0000);
    check("reset-edge DATA_Out", data_out, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    bus(1'b0, 1'b1, 16'hFF03, 16'h0000);
`ifdef NRISC_DMEM_TIMER_EN
    check("post-reset tcmp", data_out, 16'hFFFF);
`else
    check("post-reset tcmp", data_out, 16'h0000);
`endif
    bus(1'b0, 1'b1, 16'h0005, 16'h0000);
    check("write during reset dropped", data_out, 16'h1234);
    bus(1'b0, 1'b1, 16'hFF02, 16'h0000);
    check("post-reset tcount", data_out, 16'h0000);
    bus(1'b0, 1'b1, 16'hFF04, 16'h0000);
    check("post-reset tctrl", data_out, 16'h0000);
    check("post-reset DATA_valid", {15'b0, data_valid}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nrisc_data_mem.md
NRISC_DATA_MEM -- requirements
Module: nrisc_data_mem

Interface
REQ-001 SHALL have parameter TAM, default 16: data/address width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10: RAM holds 2^DEPTH_LOG2 words at addresses 0..2^DEPTH_LOG2-1.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port CORE_DATA_ADDR, input, TAM: word address from the CPU.
REQ-006 SHALL have port DATA_IN, input, TAM: write data from the CPU.
REQ-007 SHALL have port CORE_DATA_write, input, 1: write strobe, sampled each posedge.
REQ-008 SHALL have port CORE_DATA_load, input, 1: load strobe, sampled each posedge.
REQ-009 SHALL have port DATA_Out, output, TAM: read data to the CPU.
REQ-010 SHALL have port DATA_valid, output, 1: one-cycle pulse marking new DATA_Out.
REQ-011 SHALL have port GPIO_in, input, TAM: external input word.
REQ-012 SHALL have port GPIO_out, output, TAM: registered output word.
REQ-013 SHALL have port TIMER_irq, output, 1: level copy of the timer match flag.

Function
REQ-014 SHALL decode: RAM below 2^DEPTH_LOG2; 0xFF00 GPIO_out (R/W); 0xFF01 GPIO_in (RO); 0xFF02 TCOUNT (R/W); 0xFF03 TCMP (R/W); 0xFF04 TCTRL (bit0 EN, bit1 FLAG, bit2 AUTORELOAD); all other addresses unmapped.
REQ-015 SHALL commit a write at the posedge where CORE_DATA_write=1; the written value is readable by a load issued the next cycle.
REQ-016 SHALL, on a load at edge N, update DATA_Out at edge N and assert DATA_valid for exactly the cycle following edge N (latency 1).
REQ-017 SHALL hold DATA_Out unchanged when no load is accepted.
REQ-018 SHALL, when write and load are both 1 at one edge, perform only the write; DATA_Out and DATA_valid behave as if no load occurred.
REQ-019 SHALL return 0 for loads from unmapped addresses and silently ignore writes to them and to 0xFF01.
REQ-020 SHALL, while EN=1, increment TCOUNT by 1 per cycle modulo 2^TAM (0xFFFF wraps to 0x0000).
REQ-021 SHALL, when TCOUNT equals TCMP with EN=1, set FLAG on that edge; with AUTORELOAD=1, load TCOUNT to 0 on that edge instead of incrementing.
REQ-022 SHALL give a CPU write to TCOUNT priority over increment/reload on the same edge.
REQ-023 SHALL clear FLAG only when TCTRL is written with bit1=1 (write-1-to-clear); writing bit1=0 leaves FLAG; a match on the same edge as a clear leaves FLAG=1.
REQ-024 SHALL read TCTRL as {zeros, AUTORELOAD, FLAG, EN}.
REQ-025 SHALL drive TIMER_irq = FLAG.

Reset
REQ-026 SHALL, while rst=0, immediately force DATA_Out=0, DATA_valid=0, GPIO_out=0, TCOUNT=0, TCMP=0xFFFF, TCTRL=0, TIMER_irq=0.
REQ-027 SHALL leave RAM contents unspecified after reset (not cleared).
REQ-028 SHALL discard any load or write whose edge coincides with rst=0; a load pending DATA_valid is cancelled.

Configuration
REQ-029 SHALL use macro NRISC_DMEM_TIMER_EN: defined -> timer per REQ-020..025; undefined -> no timer logic, 0xFF02..0xFF04 unmapped (read 0), TIMER_irq tied 0.

Verification
REQ-030 SHALL check: write 0x1234 to 0x0005, load 0x0005 next cycle -> DATA_Out=0x1234, DATA_valid high one cycle.
REQ-031 SHALL check: write and load 0x0007 on the same edge with DATA_IN=0xAAAA -> DATA_valid stays 0; later load 0x0007 -> 0xAAAA.
REQ-032 SHALL check: load 0x8000 (unmapped, DEPTH_LOG2=10) -> DATA_Out=0x0000; write 0xFF01 then load 0xFF01 with GPIO_in=0x5A5A -> 0x5A5A.
REQ-033 SHALL check: TCMP=3, TCTRL=0x5 -> FLAG and TIMER_irq set at the edge TCOUNT reaches 3, next TCOUNT=0; write TCTRL=0x7 -> FLAG cleared, EN kept.
REQ-034 SHALL check: TCOUNT=0xFFFF, EN=1, AUTORELOAD=0, TCMP=0x0010 -> next TCOUNT=0x0000, FLAG stays 0.
REQ-035 SHALL check: assert rst=0 between clock edges mid-timer-run -> GPIO_out, TCOUNT, TCTRL, DATA_Out zero immediately, TCMP=0xFFFF.
